// File: rtl/blink_seq_monitor_if.sv
// Tail-light monitor interface: light codes and clear from the driver side,
// decoded completion, count and error results back from the monitor.
interface blink_seq_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             clr;
  logic [2:0]       lightsL;
  logic [2:0]       lightsR;
  logic             doneL;
  logic             doneR;
  logic [CNT_W-1:0] cntL;
  logic [CNT_W-1:0] cntR;
  logic             busy;
  logic             err;
  logic [1:0]       err_code;
  logic             err_side;
  logic             err_flag;

  modport master (
    output clr, lightsL, lightsR,
    input  doneL, doneR, cntL, cntR, busy, err, err_code, err_side, err_flag
  );

  modport slave (
    input  clr, lightsL, lightsR,
    output doneL, doneR, cntL, cntR, busy, err, err_code, err_side, err_flag
  );
endinterface

// File: rtl/blink_seq_monitor.sv
// Passive checker for the tail-light FSM: decodes per-side blink sequences,
// counts completed cycles and reports protocol violations.
module blink_seq_monitor #(
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  blink_seq_monitor_if.slave  mon
);
  typedef enum logic [1:0] {S_IDLE, S_A, S_B, S_C} trk_e;

  localparam logic [1:0]       E_NONE    = 2'd0;
  localparam logic [1:0]       E_ILLEGAL = 2'd1;
  localparam logic [1:0]       E_BOTH    = 2'd2;
  localparam logic [1:0]       E_STEP    = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  function automatic logic is_legal(input logic [2:0] code);
    return (code == 3'b000) || (code == 3'b001) || (code == 3'b011) || (code == 3'b111);
  endfunction

  function automatic trk_e decode(input logic [2:0] code);
    trk_e s;
    case (code)
      3'b001:  s = S_A;
      3'b011:  s = S_B;
      3'b111:  s = S_C;
      default: s = S_IDLE;
    endcase
    return s;
  endfunction

  // A new blink cycle may only start while the opposite side is idle.
  function automatic logic step_ok(input trk_e cur, input trk_e nxt, input trk_e other);
    logic ok;
    case (cur)
      S_IDLE:  ok = (nxt == S_IDLE) || ((nxt == S_A) && (other == S_IDLE));
      S_A:     ok = (nxt == S_B);
      S_B:     ok = (nxt == S_C);
      default: ok = (nxt == S_IDLE);
    endcase
    return ok;
  endfunction

  trk_e             trk_l_q, trk_l_d, trk_r_q, trk_r_d;
  logic             done_l_q, done_l_d, done_r_q, done_r_d;
  logic [CNT_W-1:0] cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
  logic             busy_q, busy_d, err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             side_q, side_d, flag_q, flag_d;

  logic ill_l, ill_r, both, bad_l, bad_r;
  trk_e dec_l, dec_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trk_l_q  <= S_IDLE;
      trk_r_q  <= S_IDLE;
      done_l_q <= 1'b0;
      done_r_q <= 1'b0;
      cnt_l_q  <= '0;
      cnt_r_q  <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= E_NONE;
      side_q   <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      trk_l_q  <= trk_l_d;
      trk_r_q  <= trk_r_d;
      done_l_q <= done_l_d;
      done_r_q <= done_r_d;
      cnt_l_q  <= cnt_l_d;
      cnt_r_q  <= cnt_r_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      code_q   <= code_d;
      side_q   <= side_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    trk_l_d  = trk_l_q;
    trk_r_d  = trk_r_q;
    done_l_d = 1'b0;
    done_r_d = 1'b0;
    cnt_l_d  = cnt_l_q;
    cnt_r_d  = cnt_r_q;
    err_d    = 1'b0;
    code_d   = code_q;
    side_d   = side_q;
    flag_d   = flag_q;

    ill_l = !is_legal(mon.lightsL);
    ill_r = !is_legal(mon.lightsR);
    dec_l = decode(mon.lightsL);
    dec_r = decode(mon.lightsR);
    both  = (mon.lightsL != 3'b000) && (mon.lightsR != 3'b000);
    bad_l = !ill_l && !step_ok(trk_l_q, dec_l, trk_r_q);
    bad_r = !ill_r && !step_ok(trk_r_q, dec_r, trk_l_q);

    done_l_d = !ill_l && (trk_l_q == S_C) && (dec_l == S_IDLE);
    done_r_d = !ill_r && (trk_r_q == S_C) && (dec_r == S_IDLE);

    // Clear restarts counters from zero but a same-cycle completion still counts.
    if (mon.clr) begin
      cnt_l_d = done_l_d ? CNT_W'(1) : '0;
      cnt_r_d = done_r_d ? CNT_W'(1) : '0;
      code_d  = E_NONE;
      side_d  = 1'b0;
      flag_d  = 1'b0;
    end else begin
      if (done_l_d && (cnt_l_q != CNT_MAX)) cnt_l_d = cnt_l_q + CNT_W'(1);
      if (done_r_d && (cnt_r_q != CNT_MAX)) cnt_r_d = cnt_r_q + CNT_W'(1);
    end

    err_d = ill_l || ill_r || both || bad_l || bad_r;
    if (err_d) begin
      flag_d = 1'b1;
      if (ill_l) begin
        code_d = E_ILLEGAL; side_d = 1'b1;
      end else if (ill_r) begin
        code_d = E_ILLEGAL; side_d = 1'b0;
      end else if (both) begin
        code_d = E_BOTH;    side_d = 1'b0;
      end else if (bad_l) begin
        code_d = E_STEP;    side_d = 1'b1;
      end else begin
        code_d = E_STEP;    side_d = 1'b0;
      end
    end

    // Trackers follow the sampled code even on a bad step, so one glitch is one error.
    trk_l_d = ill_l ? S_IDLE : dec_l;
    trk_r_d = ill_r ? S_IDLE : dec_r;
    busy_d  = (trk_l_d != S_IDLE) || (trk_r_d != S_IDLE);
  end

  assign mon.doneL    = done_l_q;
  assign mon.doneR    = done_r_q;
  assign mon.cntL     = cnt_l_q;
  assign mon.cntR     = cnt_r_q;
  assign mon.busy     = busy_q;
  assign mon.err      = err_q;
  assign mon.err_code = code_q;
  assign mon.err_side = side_q;
  assign mon.err_flag = flag_q;
endmodule

// File: tb/tb_blink_seq_monitor.sv
// Self-checking bench for blink_seq_monitor: two instances (CNT_W=8 and 2)
// driven identically and compared each cycle against a code-level model.
module tb_blink_seq_monitor;
  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  blink_seq_monitor_if #(.CNT_W(8)) m8 ();
  blink_seq_monitor_if #(.CNT_W(2)) m2 ();

  blink_seq_monitor #(.CNT_W(8)) dut8 (.clk(clk), .reset(reset), .mon(m8.slave));
  blink_seq_monitor #(.CNT_W(2)) dut2 (.clk(clk), .reset(reset), .mon(m2.slave));

  // Reference model: last legal code seen per side, unbounded completion counts.
  int         m_pl, m_pr, m_cl, m_cr;
  bit         e_done_l, e_done_r, e_busy, e_err, e_side, e_flag;
  logic [1:0] e_code;

  function automatic bit legal(input int c);
    return (c == 0) || (c == 1) || (c == 3) || (c == 7);
  endfunction

  function automatic int succ(input int c);
    case (c)
      0:       return 1;
      1:       return 3;
      3:       return 7;
      default: return 0;
    endcase
  endfunction

  function automatic bit step_ok(input int p, input int c, input int o);
    if (p == 0) return (c == 0) || (c == 1 && o == 0);
    return c == succ(p);
  endfunction

  function automatic void model_reset();
    m_pl = 0; m_pr = 0; m_cl = 0; m_cr = 0;
    e_done_l = 0; e_done_r = 0; e_busy = 0; e_err = 0;
    e_code = 2'd0; e_side = 0; e_flag = 0;
  endfunction

  function automatic void model_step(input int l, input int r, input bit c);
    bit il, ir, both, bl, br, dl, dr;
    il   = !legal(l);
    ir   = !legal(r);
    both = (l != 0) && (r != 0);
    bl   = !il && !step_ok(m_pl, l, m_pr);
    br   = !ir && !step_ok(m_pr, r, m_pl);
    dl   = (m_pl == 7) && (l == 0);
    dr   = (m_pr == 7) && (r == 0);
    e_done_l = dl;
    e_done_r = dr;
    if (c) begin
      m_cl = int'(dl); m_cr = int'(dr);
      e_flag = 0; e_code = 2'd0; e_side = 0;
    end else begin
      m_cl += int'(dl); m_cr += int'(dr);
    end
    e_err = il || ir || both || bl || br;
    if (il)        begin e_code = 2'd1; e_side = 1; end
    else if (ir)   begin e_code = 2'd1; e_side = 0; end
    else if (both) begin e_code = 2'd2; e_side = 0; end
    else if (bl)   begin e_code = 2'd3; e_side = 1; end
    else if (br)   begin e_code = 2'd3; e_side = 0; end
    if (e_err) e_flag = 1;
    m_pl = il ? 0 : l;
    m_pr = ir ? 0 : r;
    e_busy = (m_pl != 0) || (m_pr != 0);
  endfunction

  function automatic logic [35:0] exp_all();
    int a8, b8, a2, b2;
    a8 = (m_cl > 255) ? 255 : m_cl;
    b8 = (m_cr > 255) ? 255 : m_cr;
    a2 = (m_cl > 3) ? 3 : m_cl;
    b2 = (m_cr > 3) ? 3 : m_cr;
    return {e_done_l, e_done_r, 8'(a8), 8'(b8), e_busy, e_err, e_code, e_side, e_flag,
            e_done_l, e_done_r, 2'(a2), 2'(b2), e_busy, e_err, e_code, e_side, e_flag};
  endfunction

  function automatic logic [35:0] obs_all();
    return {m8.doneL, m8.doneR, m8.cntL, m8.cntR, m8.busy, m8.err, m8.err_code, m8.err_side, m8.err_flag,
            m2.doneL, m2.doneR, m2.cntL, m2.cntR, m2.busy, m2.err, m2.err_code, m2.err_side, m2.err_flag};
  endfunction

  task automatic drive(input logic [2:0] l, input logic [2:0] r, input logic c);
    m8.lightsL = l; m8.lightsR = r; m8.clr = c;
    m2.lightsL = l; m2.lightsR = r; m2.clr = c;
  endtask

  task automatic cycle(input logic [2:0] l, input logic [2:0] r, input logic c);
    drive(l, r, c);
    @(posedge clk);
    model_step(int'(l), int'(r), c);
    #1;
  endtask

  task automatic do_reset();
    drive(3'b000, 3'b000, 1'b0);
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs_all() !== 36'h0) begin
      bad++; $display("FAIL reset outputs got %h exp %h", obs_all(), 36'h0);
    end
  endtask

  task automatic test_left_seq();
    logic [2:0] seq [5] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b000};
    int busy_n = 0, err_n = 0;
    do_reset();
    foreach (seq[i]) begin
      cycle(seq[i], 3'b000, 1'b0);
      busy_n += int'(m8.busy);
      err_n  += int'(m8.err);
      total++;
      if (obs_all() !== exp_all()) begin
        bad++; $display("FAIL left_seq step %0d got %h exp %h", i, obs_all(), exp_all());
      end
    end
    total++;
    if ({m8.doneL, m8.cntL, busy_n, err_n} !== {1'b1, 8'd1, 32'd3, 32'd0}) begin
      bad++; $display("FAIL left_seq summary done=%b cnt=%0d busy=%0d err=%0d exp 1 1 3 0",
                      m8.doneL, m8.cntL, busy_n, err_n);
    end
  endtask

  task automatic test_alternate();
    logic [2:0] seq [4] = '{3'b001, 3'b011, 3'b111, 3'b000};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      foreach (seq[i]) begin
        if (k < 2) cycle(3'b000, seq[i], 1'b0);
        else       cycle(seq[i], 3'b000, 1'b0);
        total++;
        if (obs_all() !== exp_all()) begin
          bad++; $display("FAIL alternate seq %0d step %0d got %h exp %h", k, i, obs_all(), exp_all());
        end
      end
    end
    total++;
    if ({m8.cntR, m8.cntL, m8.err_flag} !== {8'd2, 8'd1, 1'b0}) begin
      bad++; $display("FAIL alternate counts cntR=%0d cntL=%0d flag=%b exp 2 1 0", m8.cntR, m8.cntL, m8.err_flag);
    end
  endtask

  task automatic test_both_active();
    do_reset();
    cycle(3'b001, 3'b001, 1'b0);
    total++;
    if ({m8.err, m8.err_code, m8.err_side, m8.err_flag, m8.cntL, m8.cntR} !== {1'b1, 2'd2, 1'b0, 1'b1, 8'd0, 8'd0}) begin
      bad++; $display("FAIL both_active got err=%b code=%0d side=%b flag=%b exp 1 2 0 1",
                      m8.err, m8.err_code, m8.err_side, m8.err_flag);
    end
    total++;
    if (obs_all() !== exp_all()) begin
      bad++; $display("FAIL both_active model got %h exp %h", obs_all(), exp_all());
    end
  endtask

  task automatic test_bad_step();
    do_reset();
    cycle(3'b001, 3'b000, 1'b0);
    cycle(3'b111, 3'b000, 1'b0);
    total++;
    if ({m8.err, m8.err_code, m8.err_side} !== {1'b1, 2'd3, 1'b1}) begin
      bad++; $display("FAIL bad_step got err=%b code=%0d side=%b exp 1 3 1", m8.err, m8.err_code, m8.err_side);
    end
    cycle(3'b000, 3'b000, 1'b0);
    total++;
    if ({m8.doneL, m8.err, m8.cntL} !== {1'b1, 1'b0, 8'd1}) begin
      bad++; $display("FAIL bad_step resync done=%b err=%b cnt=%0d exp 1 0 1", m8.doneL, m8.err, m8.cntL);
    end
  endtask

  task automatic test_illegal_code();
    logic [2:0] seq [7] = '{3'b001, 3'b011, 3'b010, 3'b001, 3'b011, 3'b111, 3'b000};
    do_reset();
    foreach (seq[i]) begin
      cycle(3'b000, seq[i], 1'b0);
      total++;
      if (obs_all() !== exp_all()) begin
        bad++; $display("FAIL illegal_code step %0d got %h exp %h", i, obs_all(), exp_all());
      end
      if (i == 2) begin
        total++;
        if ({m8.err, m8.err_code, m8.err_side, m8.busy} !== {1'b1, 2'd1, 1'b0, 1'b0}) begin
          bad++; $display("FAIL illegal_code report err=%b code=%0d side=%b busy=%b exp 1 1 0 0",
                          m8.err, m8.err_code, m8.err_side, m8.busy);
        end
      end
    end
    total++;
    if ({m8.cntR, m8.doneR} !== {8'd1, 1'b1}) begin
      bad++; $display("FAIL illegal_code recount cntR=%0d doneR=%b exp 1 1", m8.cntR, m8.doneR);
    end
  endtask

  task automatic test_saturate_clr();
    logic [2:0] seq [4] = '{3'b001, 3'b011, 3'b111, 3'b000};
    int pulses = 0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      foreach (seq[i]) begin
        cycle(seq[i], 3'b000, 1'b0);
        pulses += int'(m2.doneL);
        total++;
        if (obs_all() !== exp_all()) begin
          bad++; $display("FAIL saturate seq %0d step %0d got %h exp %h", k, i, obs_all(), exp_all());
        end
      end
    end
    total++;
    if ({m2.cntL, pulses, m8.cntL} !== {2'd3, 32'd5, 8'd5}) begin
      bad++; $display("FAIL saturate cnt2=%0d pulses=%0d cnt8=%0d exp 3 5 5", m2.cntL, pulses, m8.cntL);
    end
    cycle(3'b010, 3'b000, 1'b0);
    cycle(3'b000, 3'b000, 1'b1);
    total++;
    if ({m2.cntL, m2.err_flag, m2.err_code, m8.cntL} !== {2'd0, 1'b0, 2'd0, 8'd0}) begin
      bad++; $display("FAIL clr cnt=%0d flag=%b code=%0d exp 0 0 0", m2.cntL, m2.err_flag, m2.err_code);
    end
    // clr colliding with a completion and with an error
    cycle(3'b001, 3'b000, 1'b0);
    cycle(3'b011, 3'b000, 1'b0);
    cycle(3'b111, 3'b000, 1'b0);
    cycle(3'b000, 3'b000, 1'b0);
    cycle(3'b001, 3'b000, 1'b0);
    cycle(3'b011, 3'b000, 1'b0);
    cycle(3'b111, 3'b000, 1'b0);
    cycle(3'b000, 3'b000, 1'b1);
    total++;
    if ({m8.cntL, m8.doneL} !== {8'd1, 1'b1}) begin
      bad++; $display("FAIL clr_done cnt=%0d done=%b exp 1 1", m8.cntL, m8.doneL);
    end
    cycle(3'b000, 3'b110, 1'b1);
    total++;
    if ({m8.err, m8.err_flag, m8.err_code, m8.err_side} !== {1'b1, 1'b1, 2'd1, 1'b0}) begin
      bad++; $display("FAIL clr_err err=%b flag=%b code=%0d side=%b exp 1 1 1 0",
                      m8.err, m8.err_flag, m8.err_code, m8.err_side);
    end
    cycle(3'b000, 3'b000, 1'b0);
    cycle(3'b001, 3'b000, 1'b0);
    cycle(3'b011, 3'b000, 1'b0);
    reset = 1'b1;
    model_reset();
    #1;
    total++;
    if (obs_all() !== 36'h0) begin
      bad++; $display("FAIL async_reset got %h exp %h", obs_all(), 36'h0);
    end
    drive(3'b000, 3'b000, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(3'b011, 3'b000, 1'b0);
    total++;
    if ({m8.err, m8.err_code, m8.err_side, m8.busy} !== {1'b1, 2'd3, 1'b1, 1'b1}) begin
      bad++; $display("FAIL post_reset err=%b code=%0d side=%b busy=%b exp 1 3 1 1",
                      m8.err, m8.err_code, m8.err_side, m8.busy);
    end
  endtask

  function automatic logic [2:0] pick(input int prev);
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return 3'(succ(prev));
    if (r < 8) return 3'b000;
    if (r < 9) return 3'($urandom_range(0, 7));
    return 3'(prev);
  endfunction

  task automatic test_random();
    logic [2:0] l, r;
    logic       c;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        l = pick(m_pl);
        r = ($urandom_range(0, 9) == 0) ? pick(m_pr) : 3'b000;
      end else begin
        r = pick(m_pr);
        l = ($urandom_range(0, 9) == 0) ? pick(m_pl) : 3'b000;
      end
      c = ($urandom_range(0, 15) == 0);
      cycle(l, r, c);
      total++;
      if (obs_all() !== exp_all()) begin
        bad++; $display("FAIL random cycle %0d l=%b r=%b clr=%b got %h exp %h", n, l, r, c, obs_all(), exp_all());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(3'b000, 3'b000, 1'b0);
    test_reset();
    test_left_seq();
    test_alternate();
    test_both_active();
    test_bad_step();
    test_illegal_code();
    test_saturate_clr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
